// File: rtl/pipeline_ctrl_pkg.sv
// Shared FSM state encoding and helpers for the pipeline controller.
package pipeline_ctrl_pkg;

    localparam int NB_STATE = 2;

    typedef enum logic [NB_STATE-1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Drain counter needs at least one bit even for a single-cycle drain.
    function automatic int drain_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones, sync active-high reset.
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_inc,
    output logic [NB-1:0] o_count
);

    logic [NB-1:0] count_q;
    logic [NB-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {NB{1'b1}})) begin
            count_d = count_q + NB'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline write-enable / HALT sequencing controller for the 5-stage MIPS core.
// Optional perf counters (stall, flush) are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_COUNTER        = 32,
    parameter int HALT_DRAIN_CYCLES = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_risk_detected,
    input  logic                  i_if_flush,
    input  logic                  i_halt_id,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_bubble,
    output logic                  o_pipe_enable,
    output logic                  o_halted,
    output logic [NB_STATE-1:0]   o_state,
    output logic [NB_COUNTER-1:0] o_cycle_count
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [NB_COUNTER-1:0] o_stall_count,
    output logic [NB_COUNTER-1:0] o_flush_count
`endif
);

    localparam int                NB_DRAIN   = drain_width(HALT_DRAIN_CYCLES);
    localparam logic [NB_DRAIN-1:0] DRAIN_INIT = NB_DRAIN'(HALT_DRAIN_CYCLES - 1);

    state_e              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic                active;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Inactive cycles in RUN/DRAIN leave every enable low so the whole pipe freezes.
    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pipe_enable  = 1'b0;
        active         = i_enable && ((state_q == RUN) || (state_q == DRAIN));

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_enable) begin
                    o_pipe_enable = 1'b1;
                    if (i_risk_detected) begin
                        o_id_ex_bubble = 1'b1;
                    end else if (i_halt_id) begin
                        o_if_id_write = 1'b1;
                        o_if_id_flush = 1'b1;
                        drain_d       = DRAIN_INIT;
                        state_d       = DRAIN;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                        o_if_id_flush = i_if_flush;
                    end
                end
            end
            DRAIN: begin
                // Fetch is stopped; NOPs are fed into IF/ID while older instructions retire.
                if (i_enable) begin
                    o_if_id_write = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_pipe_enable = 1'b1;
                    if (drain_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q - NB_DRAIN'(1);
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_halted = (state_q == HALTED);
    assign o_state  = state_q;

    sat_counter #(.NB(NB_COUNTER)) u_cycle_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (active),
        .o_count (o_cycle_count)
    );

`ifdef PIPELINE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = active && (state_q == RUN) && i_risk_detected;
    assign flush_inc = active && (state_q == RUN) && i_if_flush && !i_risk_detected && !i_halt_id;

    sat_counter #(.NB(NB_COUNTER)) u_stall_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (stall_inc),
        .o_count (o_stall_count)
    );

    sat_counter #(.NB(NB_COUNTER)) u_flush_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (flush_inc),
        .o_count (o_flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a 32-bit instance plus a 4-bit instance for saturation.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic risk = 1'b0;
    logic flush = 1'b0;
    logic halt = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_enable, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_cycle_count;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_count, flush_count;
    logic [3:0]  s_stall_count, s_flush_count;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(.NB_COUNTER(32), .HALT_DRAIN_CYCLES(4)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_risk_detected (risk),
        .i_if_flush      (flush),
        .i_halt_id       (halt),
        .o_pc_write      (pc_write),
        .o_if_id_write   (if_id_write),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_bubble  (id_ex_bubble),
        .o_pipe_enable   (pipe_enable),
        .o_halted        (halted),
        .o_state         (state),
        .o_cycle_count   (cycle_count)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .o_stall_count   (stall_count),
        .o_flush_count   (flush_count)
`endif
    );

    pipeline_ctrl #(.NB_COUNTER(4), .HALT_DRAIN_CYCLES(4)) dut_sat (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_enable        (en),
        .i_risk_detected (risk),
        .i_if_flush      (flush),
        .i_halt_id       (halt),
        .o_pc_write      (s_pc_write),
        .o_if_id_write   (s_if_id_write),
        .o_if_id_flush   (s_if_id_flush),
        .o_id_ex_bubble  (s_id_ex_bubble),
        .o_pipe_enable   (s_pipe_enable),
        .o_halted        (s_halted),
        .o_state         (s_state),
        .o_cycle_count   (s_cycle_count)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .o_stall_count   (s_stall_count),
        .o_flush_count   (s_flush_count)
`endif
    );

    // ctl packs {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted, state[1:0]}
    typedef struct {
        logic [7:0] ctl;
        int         cyc;
        int         stall;
        int         fcnt;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string nm, input string what, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s/%s: got %h expected %h", nm, what, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, "ctl", {24'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                                pipe_enable, halted, state}, {24'd0, e.ctl});
            check(e.nm, "cycle_count", cycle_count, e.cyc);
            check(e.nm, "sat_cycle_count", {28'd0, s_cycle_count}, (e.cyc > 15) ? 15 : e.cyc);
`ifdef PIPELINE_CTRL_PERF_EN
            check(e.nm, "stall_count", stall_count, e.stall);
            check(e.nm, "flush_count", flush_count, e.fcnt);
`endif
        end
    end

    task automatic step(input logic r, input logic e, input logic rk, input logic fl, input logic hl,
                        input bit chk, input logic [7:0] ctl, input int cyc, input int stl,
                        input int fc, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst   = r;
        en    = e;
        risk  = rk;
        flush = fl;
        halt  = hl;
        if (chk) begin
            x.ctl   = ctl;
            x.cyc   = cyc;
            x.stall = stl;
            x.fcnt  = fc;
            x.nm    = nm;
            sb.push_back(x);
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "rst");
        step(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "rst");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, "t1_idle");

        step(0, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0, "t2_idle_to_run");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 1, 8'hC9, i, 0, 0, "t2_run");
        step(0, 0, 0, 0, 0, 1, 8'h01, 10, 0, 0, "t2_freeze");

        step(0, 1, 1, 1, 0, 1, 8'h19, 10, 0, 0, "t3_risk_flush");
        step(0, 1, 0, 1, 0, 1, 8'hE9, 11, 1, 0, "t3_flush");
        step(0, 0, 0, 0, 0, 1, 8'h01, 12, 1, 1, "t3_freeze");

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 1, 8'hC9, 12 + i, 1, 1, "t5_pulse");
            step(0, 0, 0, 0, 0, 1, 8'h01, 13 + i, 1, 1, "t5_gap");
        end

        step(0, 1, 1, 0, 1, 1, 8'h19, 15, 1, 1, "risk_over_halt");
        step(0, 1, 0, 0, 1, 1, 8'h69, 16, 2, 1, "t4_halt");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 1, 1, 8'h6A, 17 + i, 2, 1, "t4_drain_active");
            step(0, 0, 0, 0, 0, 1, (i == 3) ? 8'h07 : 8'h02, 18 + i, 2, 1, "t4_drain_idle");
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 8'h07, 21, 2, 1, "t4_halted_enable");

        step(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "rst");
        step(0, 1, 0, 0, 0, 1, 8'h00, 0, 0, 0, "t6_idle");
        step(0, 1, 0, 0, 1, 1, 8'h69, 0, 0, 0, "t6_halt");
        step(0, 1, 0, 0, 0, 1, 8'h6A, 1, 0, 0, "t6_drain");
        step(1, 1, 0, 0, 0, 1, 8'h6A, 2, 0, 0, "t6_reset_mid_drain");
        step(0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, "t6_after_reset");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
